// File: rtl/traffic_phase_scheduler.sv
// Round-robin, tick-timed green/yellow/all-red scheduler for a four-lane intersection.
// Latches demand, grants one lane at a time and extends a congested green a bounded number of times.
module traffic_phase_scheduler #(
  parameter int GREEN_TIME  = 10,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 2,
  parameter int EXT_TIME    = 5,
  parameter int MAX_EXT     = 1,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic [3:0] i_demand,
  input  logic [3:0] i_congest,
  output logic [3:0] o_light_signal,
  output logic [1:0] o_phase,
  output logic [1:0] o_lane,
  output logic [3:0] o_pending,
  output logic       o_ext_active
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    ALLRED = 2'b11
  } phase_t;

  localparam int EW = $clog2(MAX_EXT + 2);

  phase_t        r_phase, w_nextPhase;
  logic [1:0]    r_lane, w_nextLane, w_winner;
  logic [TW-1:0] r_timer, w_nextTimer;
  logic [EW-1:0] r_extCount, w_nextExtCount;
  logic          r_extActive, w_nextExtActive;
  logic [3:0]    r_pending, w_nextPending, w_req;
  logic [3:0]    r_light, w_nextLight;
  logic          w_expire, w_grant, w_found;

  assign w_req    = r_pending | i_demand;
  assign w_expire = i_tick && (r_timer == '0);

  // Search starts one past the last green lane; the last green lane itself is tried last.
  always_comb begin
    w_winner = r_lane;
    w_found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_req[r_lane + 2'(k)]) begin
        w_winner = r_lane + 2'(k);
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_nextPhase     = r_phase;
    w_nextLane      = r_lane;
    w_nextTimer     = r_timer;
    w_nextExtCount  = r_extCount;
    w_nextExtActive = r_extActive;
    w_grant         = 1'b0;
    if (i_tick && !w_expire) begin
      w_nextTimer = r_timer - 1'b1;
    end
    case (r_phase)
      IDLE: begin
        if (|w_req) begin
          w_grant = 1'b1;
        end
      end
      GREEN: begin
        if (w_expire) begin
          if (i_congest[r_lane] && (int'(r_extCount) < MAX_EXT)) begin
            w_nextTimer     = TW'(EXT_TIME - 1);
            w_nextExtCount  = r_extCount + 1'b1;
            w_nextExtActive = 1'b1;
          end else begin
            w_nextPhase     = YELLOW;
            w_nextTimer     = TW'(YELLOW_TIME - 1);
            w_nextExtActive = 1'b0;
          end
        end
      end
      YELLOW: begin
        if (w_expire) begin
          w_nextPhase = ALLRED;
          w_nextTimer = TW'(ALLRED_TIME - 1);
        end
      end
      ALLRED: begin
        if (w_expire) begin
          if (|w_req) begin
            w_grant = 1'b1;
          end else begin
            w_nextPhase = IDLE;
          end
        end
      end
      default: w_nextPhase = IDLE;
    endcase
    if (w_grant) begin
      w_nextPhase     = GREEN;
      w_nextLane      = w_winner;
      w_nextTimer     = TW'(GREEN_TIME - 1);
      w_nextExtCount  = '0;
      w_nextExtActive = 1'b0;
    end
  end

  // The green lane ignores its own demand; a grant clear wins over a same-cycle set.
  always_comb begin
    w_nextPending = r_pending | i_demand;
    if (r_phase == GREEN) begin
      w_nextPending[r_lane] = r_pending[r_lane];
    end
    if (w_grant) begin
      w_nextPending[w_winner] = 1'b0;
    end
  end

  always_comb begin
    w_nextLight = 4'd0;
    case (w_nextPhase)
      GREEN:   w_nextLight = {1'b0, w_nextLane, 1'b1};
      YELLOW:  w_nextLight = {1'b0, w_nextLane, 1'b0} + 4'd2;
      default: w_nextLight = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= IDLE;
      r_lane      <= 2'd3;
      r_timer     <= '0;
      r_extCount  <= '0;
      r_extActive <= 1'b0;
      r_pending   <= 4'd0;
      r_light     <= 4'd0;
    end else begin
      r_phase     <= w_nextPhase;
      r_lane      <= w_nextLane;
      r_timer     <= w_nextTimer;
      r_extCount  <= w_nextExtCount;
      r_extActive <= w_nextExtActive;
      r_pending   <= w_nextPending;
      r_light     <= w_nextLight;
    end
  end

  assign o_phase        = r_phase;
  assign o_lane         = r_lane;
  assign o_pending      = r_pending;
  assign o_ext_active   = r_extActive;
  assign o_light_signal = r_light;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase lengths, round-robin order,
// extensions, request latching and slow timebase, with hand-computed expectations.
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       rst;
  logic       i_tick;
  logic [3:0] i_demand;
  logic [3:0] i_congest;
  logic [3:0] o_light_signal;
  logic [1:0] o_phase;
  logic [1:0] o_lane;
  logic [3:0] o_pending;
  logic       o_ext_active;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit slowTick = 0;

  traffic_phase_scheduler dut (
    .clk(clk),
    .rst(rst),
    .i_tick(i_tick),
    .i_demand(i_demand),
    .i_congest(i_congest),
    .o_light_signal(o_light_signal),
    .o_phase(o_phase),
    .o_lane(o_lane),
    .o_pending(o_pending),
    .o_ext_active(o_ext_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock cycle with dem applied for that cycle only; outputs are then read 1 time unit after the edge.
  task automatic applyStimulus(input logic [3:0] dem);
    i_demand = dem;
    @(posedge clk);
    #1;
    i_demand = 4'd0;
    cyc++;
    if (slowTick) i_tick = (cyc % 4 == 0);
  endtask

  task automatic measure(input logic [1:0] p, input logic [3:0] lightExp, output int n,
                         output int lightBad, output int extN);
    n = 0;
    lightBad = 0;
    extN = 0;
    while (o_phase === p && n < 100) begin
      if (o_light_signal !== lightExp) lightBad++;
      if (o_ext_active === 1'b1) extN++;
      n++;
      applyStimulus(4'd0);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n, lb, en, idleBad;
    logic [3:0] expPend;
    rst = 1'b1;
    i_tick = 1'b0;
    i_demand = 4'd0;
    i_congest = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstPhase", o_phase, 0);
    checkOutput("rstLight", o_light_signal, 0);
    checkOutput("rstLane", o_lane, 3);
    checkOutput("rstPending", o_pending, 0);
    checkOutput("rstExt", o_ext_active, 0);

    i_tick = 1'b1;
    idleBad = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(4'd0);
      if (o_phase !== 2'd0 || o_light_signal !== 4'd0 || o_pending !== 4'd0) idleBad++;
    end
    checkOutput("idle50", idleBad, 0);

    applyStimulus(4'b0001);
    repeat (3) applyStimulus(4'd0);
    checkOutput("preRstPhase", o_phase, 1);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstPhase", o_phase, 0);
    checkOutput("asyncRstLight", o_light_signal, 0);
    checkOutput("asyncRstLane", o_lane, 3);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pulse on lane 2 from idle.
    applyStimulus(4'b0100);
    checkOutput("p2Phase", o_phase, 1);
    checkOutput("p2Light", o_light_signal, 5);
    checkOutput("p2Pending", o_pending, 0);
    measure(2'd1, 4'd5, n, lb, en);
    checkOutput("p2GreenLen", n, 10);
    checkOutput("p2GreenLight", lb, 0);
    measure(2'd2, 4'd6, n, lb, en);
    checkOutput("p2YellowLen", n, 3);
    checkOutput("p2YellowLight", lb, 0);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("p2AllredLen", n, 2);
    checkOutput("p2AllredLight", lb, 0);
    checkOutput("p2Idle", o_phase, 0);

    // All four lanes requested at once.
    doReset();
    applyStimulus(4'b1111);
    for (int i = 0; i < 4; i++) begin
      expPend = 4'hE << i;
      checkOutput("rrLane", o_lane, i);
      checkOutput("rrPending", o_pending, expPend);
      measure(2'd1, 4'(2 * i + 1), n, lb, en);
      checkOutput("rrGreenLen", n, 10);
      checkOutput("rrGreenLight", lb, 0);
      measure(2'd2, 4'(2 * i + 2), n, lb, en);
      checkOutput("rrYellowLen", n, 3);
      checkOutput("rrYellowLight", lb, 0);
      measure(2'd3, 4'd0, n, lb, en);
      checkOutput("rrAllredLen", n, 2);
    end
    checkOutput("rrIdle", o_phase, 0);

    // Congested lane 0, one extension allowed per green.
    doReset();
    i_congest = 4'b0001;
    applyStimulus(4'b0001);
    checkOutput("exEntryExt", o_ext_active, 0);
    measure(2'd1, 4'd1, n, lb, en);
    checkOutput("exGreenLen", n, 15);
    checkOutput("exExtCycles", en, 5);
    checkOutput("exYellowExt", o_ext_active, 0);
    applyStimulus(4'b0001);
    checkOutput("exPending", o_pending, 4'b0001);
    measure(2'd2, 4'd2, n, lb, en);
    checkOutput("exYellowRest", n, 2);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("exAllredLen", n, 2);
    checkOutput("exRegrantLight", o_light_signal, 1);
    measure(2'd1, 4'd1, n, lb, en);
    checkOutput("exGreenLen2", n, 15);
    checkOutput("exExtCycles2", en, 5);
    i_congest = 4'd0;
    measure(2'd2, 4'd2, n, lb, en);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("exIdle", o_phase, 0);

    // Round-robin from lane 1 with lanes 0 and 3 pending.
    doReset();
    applyStimulus(4'b0010);
    checkOutput("rbLane1", o_lane, 1);
    measure(2'd1, 4'd3, n, lb, en);
    applyStimulus(4'b1001);
    checkOutput("rbPending", o_pending, 4'b1001);
    measure(2'd2, 4'd4, n, lb, en);
    checkOutput("rbYellowRest", n, 2);
    checkOutput("rbAllredLane", o_lane, 1);
    checkOutput("rbAllredPhase", o_phase, 3);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("rbLane3", o_lane, 3);
    checkOutput("rbLight7", o_light_signal, 7);
    checkOutput("rbPend3", o_pending, 4'b0001);
    applyStimulus(4'b1000);
    checkOutput("rbOwnDemand", o_pending, 4'b0001);
    measure(2'd1, 4'd7, n, lb, en);
    checkOutput("rbGreen3Rest", n, 9);
    measure(2'd2, 4'd8, n, lb, en);
    checkOutput("rbYellow3Len", n, 3);
    checkOutput("rbYellow3Light", lb, 0);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("rbLane0", o_lane, 0);
    checkOutput("rbLight1", o_light_signal, 1);
    checkOutput("rbPendEmpty", o_pending, 0);
    measure(2'd1, 4'd1, n, lb, en);
    measure(2'd2, 4'd2, n, lb, en);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("rbIdle", o_phase, 0);

    // Tick every 4th cycle.
    doReset();
    slowTick = 1;
    cyc = 0;
    i_tick = 1'b0;
    applyStimulus(4'b0001);
    measure(2'd1, 4'd1, n, lb, en);
    checkOutput("stGreenLen", n, 40);
    applyStimulus(4'b0010);
    checkOutput("stPending", o_pending, 4'b0010);
    measure(2'd2, 4'd2, n, lb, en);
    checkOutput("stYellowRest", n, 11);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("stAllredLen", n, 8);
    checkOutput("stLane1", o_lane, 1);
    checkOutput("stLight3", o_light_signal, 3);
    checkOutput("stPendClr", o_pending, 0);
    measure(2'd1, 4'd3, n, lb, en);
    checkOutput("stGreen1Len", n, 40);
    measure(2'd2, 4'd4, n, lb, en);
    checkOutput("stYellow1Len", n, 12);
    measure(2'd3, 4'd0, n, lb, en);
    checkOutput("stIdle", o_phase, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Timed, demand-driven scheduler for the four-lane intersection: NS1, NS2, EW1 and EW2, lane indices 0 to 3.
- Latches start-sensor requests and grants green to one lane at a time, round-robin.
- Times each green/yellow/all-red interval against a tick, and grants bounded green extensions on congestion.
- Sits between the raw S1/S5 sensors and the lamp drivers. Uses the same light_signal code as the existing light FSM.

Parameters:
- GREEN_TIME, 10: base green length, in ticks.
- YELLOW_TIME, 3: yellow length, in ticks.
- ALLRED_TIME, 2: all-red clearance after yellow, in ticks.
- EXT_TIME, 5: length of one green extension, in ticks.
- MAX_EXT, 1: maximum extensions per green phase (0 disables extension).
- TW, 8: timer width. All *_TIME values must be >= 1 and <= 2^TW.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- tick, input, 1: timebase enable, one clk cycle wide. Timers advance only when it is high.
- demand, input, 4: start sensors (S1), bit i = lane i. Level or pulse.
- congest, input, 4: congestion sensors (S5), bit i = lane i.
- light_signal, output, 4: lamp code. 0 = all red; lane i green = 2i+1; lane i yellow = 2i+2.
- phase, output, 2: 00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED.
- lane, output, 2: lane owning the current or most recent green.
- pending, output, 4: latched request vector.
- ext_active, output, 1: high while the current green is running an extension interval.

Behaviour:
- All outputs are registered. light_signal is a registered decode of phase and lane.
- Reset (asynchronous), regardless of current phase:
  - phase = IDLE, light_signal = 0, lane = 3 (so lane 0 has first priority), pending = 0, ext_active = 0.
  - Timer and extension count cleared.
- Request latch, evaluated every cycle:
  - pending[i] is set by demand[i], except demand on the lane currently in GREEN, which is ignored.
  - pending[i] is cleared on the cycle lane i is granted; a clear on grant beats a simultaneous set.
  - req = pending | demand is used for arbitration.
- Arbitration: round-robin. Search lane+1, lane+2, lane+3, lane (mod 4); the first set bit of req wins.
- Timer: loaded with T-1 on phase entry. Decrements on each tick; the phase expires on a tick while the timer is 0. Each phase therefore lasts exactly T ticks, i.e. T cycles with tick held high.
- IDLE:
  - Holds light_signal = 0.
  - If req != 0: next cycle enter GREEN on the winning lane, timer = GREEN_TIME-1, extension count = 0. Tick is not needed for this transition.
  - Otherwise stay in IDLE.
- GREEN, on expiry:
  - If congest[lane] = 1 and extension count < MAX_EXT: stay GREEN, timer = EXT_TIME-1, extension count +1, ext_active = 1.
  - Otherwise go to YELLOW, timer = YELLOW_TIME-1, ext_active = 0.
  - congest is sampled only at the expiry tick.
- YELLOW, on expiry: go to ALLRED, timer = ALLRED_TIME-1.
- ALLRED, on expiry:
  - If req != 0: go to GREEN on the arbitration winner (the same lane may win again if it re-requested).
  - Otherwise go to IDLE.
- lane changes only on entry to GREEN and holds through YELLOW, ALLRED and IDLE.
- Only one lane can be non-red at any time. light_signal is 0 in IDLE and ALLRED.
- No combinational path from any input to any output.

Test Plan:
- Reset, then tick = 1 and demand = 0 for 50 cycles -> phase = 00, light_signal = 0, pending = 0 throughout. Assert rst mid-GREEN -> light_signal = 0 and phase = 00 immediately, without waiting for a clk edge.
- One-cycle pulse demand = 0100 at cycle t, from IDLE -> GREEN for cycles t+1 to t+10 (light_signal = 5), YELLOW for t+11 to t+13 (6), ALLRED for t+14 to t+15 (0), then IDLE. pending[2] = 0 from t+1.
- demand = 1111 pulsed once from reset -> greens in order lane 0, 1, 2, 3 (light_signal = 1, 3, 5, 7). Each green is 10 cycles with 5 cycles of yellow plus all-red between. IDLE after the last all-red.
- congest = 0001 held during lane-0 green, MAX_EXT = 1 -> green lasts 15 cycles, ext_active high for the last 5, then yellow. Next lane-0 green with congest held -> again exactly 15 cycles.
- lane = 1 in ALLRED with pending = 1001 -> next green goes to lane 3 (light_signal = 7), then lane 0. Lane-3 demand pulsed during lane-3 green is not latched: pending[3] stays 0.
- tick pulsed every 4th cycle -> green lasts 40 clk cycles and yellow 12. demand[1] pulsed during yellow -> pending[1] = 1 and lane 1 is granted at the ALLRED expiry.
